// File: rtl/puf_crp_sequencer.sv
// puf_crp_sequencer: sequences one challenge-response exchange with a PUF.
// A challenge from the UART receiver is latched, the PUF is held in reset for
// SETTLE_CYCLES, released, and its response (or CHECK_PATTERN) is handed to
// the 128-bit UART transmitter.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   rx_done, rx_data             challenge input (rising edge of rx_done = new word)
//   check                        1 = transmit CHECK_PATTERN instead of the response
//   puf_start, puf_challenge     PUF control (puf_start=0 holds the PUF in reset)
//   puf_done, puf_response       PUF completion (rising edge) and result
//   tx_start, tx_data, tx_done   transmitter handshake
//   busy, timeout_err, overrun   status (the two error flags are sticky)
//   crp_count                    completed transmissions, wraps at 2^16
//   state                        current FSM state code
module puf_crp_sequencer #(
  parameter int unsigned  SETTLE_CYCLES  = 16,
  parameter int unsigned  TIMEOUT_CYCLES = 1000000,
  parameter logic [127:0] CHECK_PATTERN  = 128'hABCDEF9876543210ABCDEF9876543210
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_done,
  input  logic [15:0]  rx_data,
  input  logic         check,
  output logic         puf_start,
  output logic [15:0]  puf_challenge,
  input  logic         puf_done,
  input  logic [127:0] puf_response,
  output logic         tx_start,
  output logic [127:0] tx_data,
  input  logic         tx_done,
  output logic         busy,
  output logic         timeout_err,
  output logic         overrun,
  output logic [15:0]  crp_count,
  output logic [2:0]   state
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSettle  = 3'd1,
    StEval    = 3'd2,
    StCapture = 3'd3,
    StSend    = 3'd4,
    StWaitTx  = 3'd5
  } state_e;

  state_e         state_q, state_d;
  logic [31:0]    wait_q, wait_d;
  logic [15:0]    challenge_q, challenge_d;
  logic [127:0]   tx_data_q, tx_data_d;
  logic           timeout_q, timeout_d;
  logic           overrun_q, overrun_d;
  logic [15:0]    crp_count_q, crp_count_d;
  logic           rx_done_q, puf_done_q, tx_done_q;
  logic           rx_rise, puf_rise, tx_rise;

  assign rx_rise  = rx_done & ~rx_done_q;
  assign puf_rise = puf_done & ~puf_done_q;
  assign tx_rise  = tx_done & ~tx_done_q;

  always_comb begin
    state_d     = state_q;
    challenge_d = challenge_q;
    tx_data_d   = tx_data_q;
    timeout_d   = timeout_q;
    overrun_d   = overrun_q;
    crp_count_d = crp_count_q;

    case (state_q)
      StIdle: begin
        if (rx_rise) begin
          challenge_d = rx_data;
          timeout_d   = 1'b0;
          overrun_d   = 1'b0;
          state_d     = StSettle;
        end
      end
      StSettle: begin
        if (wait_q == 32'(SETTLE_CYCLES - 1)) state_d = StEval;
      end
      StEval: begin
        // Completion wins over a timeout landing in the same cycle.
        if (puf_rise) begin
          state_d = StCapture;
        end else if (wait_q == 32'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
      StCapture: begin
        tx_data_d = check ? CHECK_PATTERN : puf_response;
        state_d   = StSend;
      end
      StSend: begin
        state_d = StWaitTx;
      end
      StWaitTx: begin
        if (tx_rise) begin
          crp_count_d = crp_count_q + 16'd1;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A challenge arriving mid-transaction is dropped and flagged.
    if (rx_rise && (state_q != StIdle)) overrun_d = 1'b1;

    if (state_d != state_q) begin
      wait_d = '0;
    end else if (wait_q == 32'hFFFF_FFFF) begin
      wait_d = wait_q;
    end else begin
      wait_d = wait_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      wait_q      <= '0;
      challenge_q <= '0;
      tx_data_q   <= '0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
      crp_count_q <= '0;
      rx_done_q   <= 1'b0;
      puf_done_q  <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      challenge_q <= challenge_d;
      tx_data_q   <= tx_data_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
      crp_count_q <= crp_count_d;
      rx_done_q   <= rx_done;
      puf_done_q  <= puf_done;
      tx_done_q   <= tx_done;
    end
  end

  // Decoded straight from the state register so reset forces them low at once.
  assign puf_start     = (state_q == StEval) || (state_q == StCapture) ||
                         (state_q == StSend) || (state_q == StWaitTx);
  assign tx_start      = (state_q == StSend);
  assign busy          = (state_q != StIdle);
  assign puf_challenge = challenge_q;
  assign tx_data       = tx_data_q;
  assign timeout_err   = timeout_q;
  assign overrun       = overrun_q;
  assign crp_count     = crp_count_q;
  assign state         = state_q;

endmodule

// File: tb/tb_puf_crp_sequencer.sv
module tb_puf_crp_sequencer;

  localparam int unsigned  SETTLE  = 4;
  localparam int unsigned  TIMEOUT = 100;
  localparam logic [127:0] PATTERN = 128'hABCDEF9876543210ABCDEF9876543210;
  localparam logic [127:0] RESP_A  = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] RESP_B  = 128'h00000000111111112222222233333333;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx_done = 1'b0;
  logic [15:0]  rx_data = '0;
  logic         check = 1'b0;
  logic         puf_start;
  logic [15:0]  puf_challenge;
  logic         puf_done = 1'b0;
  logic [127:0] puf_response = '0;
  logic         tx_start;
  logic [127:0] tx_data;
  logic         tx_done = 1'b0;
  logic         busy;
  logic         timeout_err;
  logic         overrun;
  logic [15:0]  crp_count;
  logic [2:0]   state;

  puf_crp_sequencer #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT),
    .CHECK_PATTERN (PATTERN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_done      (rx_done),
    .rx_data      (rx_data),
    .check        (check),
    .puf_start    (puf_start),
    .puf_challenge(puf_challenge),
    .puf_done     (puf_done),
    .puf_response (puf_response),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_done      (tx_done),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .overrun      (overrun),
    .crp_count    (crp_count),
    .state        (state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model: what the architectural outputs must hold.
  logic [15:0]  exp_challenge = '0;
  logic [15:0]  exp_count     = '0;
  logic [127:0] exp_tx_data   = '0;
  logic         exp_timeout   = 1'b0;
  logic         exp_overrun   = 1'b0;
  int           exp_tx_pulses = 0;
  int           seen_tx_pulses = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model and the state-derived output rules.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("puf_start_rule", puf_start, (state >= 3'd2) && (state <= 3'd5));
      chk("tx_start_rule", tx_start, state == 3'd4);
      chk("busy_rule", busy, state != 3'd0);
      chk("challenge_model", puf_challenge, exp_challenge);
      chk("count_model", crp_count, exp_count);
      chk("tx_data_model", tx_data, exp_tx_data);
      if (state == 3'd0) begin
        chk("timeout_model", timeout_err, exp_timeout);
        chk("overrun_model", overrun, exp_overrun);
      end
      if (tx_start) seen_tx_pulses++;
    end
  end

  // Accept a challenge; measure SETTLE length; return at first EVAL negedge.
  task automatic send_challenge(input logic [15:0] c);
    int n;
    @(negedge clk);
    rx_data = c;
    rx_done = 1'b1;
    exp_challenge = c;
    exp_timeout = 1'b0;
    exp_overrun = 1'b0;
    n = 0;
    for (int i = 0; i < int'(SETTLE) + 10; i++) begin
      @(negedge clk);
      rx_done = 1'b0;
      chk("puf_start_low_settle", puf_start, (state == 3'd1) ? 1'b0 : puf_start);
      if (state == 3'd1) n++;
      else break;
    end
    chk("settle_len", n, SETTLE);
    chk("enter_eval", state, 3'd2);
    chk("timeout_cleared", timeout_err, 1'b0);
    chk("overrun_cleared", overrun, 1'b0);
  endtask

  // puf_done rises `delay` cycles into EVAL (stuck: first held high, then re-raised).
  task automatic do_eval(input int delay, input bit stuck);
    if (stuck) begin
      repeat (delay) @(negedge clk);
      chk("stuck_no_completion", state, 3'd2);
      puf_done = 1'b0;
      @(negedge clk);
      chk("stuck_after_fall", state, 3'd2);
    end else begin
      repeat (delay - 1) @(negedge clk);
    end
    puf_done = 1'b1;
    @(negedge clk);
    chk("enter_capture", state, 3'd3);
  endtask

  task automatic capture_to_wait(input bit chk_bit, input logic [127:0] lit_tx);
    check = chk_bit;
    exp_tx_data = chk_bit ? PATTERN : puf_response;
    exp_tx_pulses++;
    @(negedge clk);
    check = ~chk_bit;  // must not affect the captured word
    chk("send_state", state, 3'd4);
    chk("tx_start_pulse", tx_start, 1'b1);
    chk("tx_data_literal", tx_data, lit_tx);
    @(negedge clk);
    chk("wait_tx_state", state, 3'd5);
    chk("tx_start_one_cycle", tx_start, 1'b0);
    puf_done = 1'b0;
    check = 1'b0;
    repeat (3) @(negedge clk);
    chk("wait_tx_holds", state, 3'd5);
    chk("tx_data_stable", tx_data, lit_tx);
  endtask

  task automatic finish_tx(input logic [15:0] lit_count);
    tx_done = 1'b1;
    exp_count = exp_count + 16'd1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("back_to_idle", state, 3'd0);
    chk("count_literal", crp_count, lit_count);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, state, 3'd0);
    chk({tag, "_puf_start"}, puf_start, 1'b0);
    chk({tag, "_tx_start"}, tx_start, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_timeout"}, timeout_err, 1'b0);
    chk({tag, "_overrun"}, overrun, 1'b0);
    chk({tag, "_count"}, crp_count, 16'h0000);
    chk({tag, "_challenge"}, puf_challenge, 16'h0000);
    chk({tag, "_tx_data"}, tx_data, 128'h0);
  endtask

  initial begin
    int n;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal flow, check=0.
    puf_response = RESP_A;
    send_challenge(16'h1234);
    chk("challenge_literal", puf_challenge, 16'h1234);
    do_eval(50, 1'b0);
    capture_to_wait(1'b0, RESP_A);
    finish_tx(16'h0001);

    // check=1 overrides the PUF response.
    puf_response = RESP_B;
    send_challenge(16'h5A5A);
    do_eval(7, 1'b0);
    capture_to_wait(1'b1, 128'hABCDEF9876543210ABCDEF9876543210);
    finish_tx(16'h0002);

    // Overrun during EVAL.
    send_challenge(16'h1234);
    rx_data = 16'hBEEF;
    rx_done = 1'b1;
    exp_overrun = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    do_eval(20, 1'b0);
    chk("overrun_keeps_challenge", puf_challenge, 16'h1234);
    capture_to_wait(1'b0, RESP_B);
    finish_tx(16'h0003);
    chk("overrun_set", overrun, 1'b1);

    // Timeout: puf_done never rises.
    send_challenge(16'h0F0F);
    exp_timeout = 1'b1;
    n = 1;
    for (int i = 0; i < int'(TIMEOUT) + 10; i++) begin
      @(negedge clk);
      if (state != 3'd2) break;
      n++;
    end
    chk("eval_len_to_timeout", n, TIMEOUT);
    chk("timeout_set", timeout_err, 1'b1);
    chk("timeout_idle", state, 3'd0);
    chk("timeout_count_same", crp_count, 16'h0003);

    // Stuck-high puf_done on EVAL entry; this challenge also clears timeout_err.
    puf_done = 1'b1;
    puf_response = RESP_A;
    send_challenge(16'h7777);
    do_eval(10, 1'b1);
    capture_to_wait(1'b0, RESP_A);
    finish_tx(16'h0004);

    // Preload the counter to its maximum and wrap it.
    @(negedge clk);
    #1;
    force dut.crp_count_q = 16'hFFFF;
    exp_count = 16'hFFFF;
    #2;
    release dut.crp_count_q;
    @(negedge clk);
    chk("preload", crp_count, 16'hFFFF);
    send_challenge(16'h2222);
    do_eval(3, 1'b0);
    capture_to_wait(1'b0, RESP_A);
    finish_tx(16'h0000);
    send_challenge(16'h3333);
    do_eval(3, 1'b0);
    capture_to_wait(1'b0, RESP_A);
    finish_tx(16'h0001);

    // Reset asserted in WAIT_TX aborts everything at once.
    send_challenge(16'h4444);
    do_eval(3, 1'b0);
    capture_to_wait(1'b0, RESP_A);
    rst = 1'b1;
    exp_challenge = '0;
    exp_count = '0;
    exp_tx_data = '0;
    exp_timeout = 1'b0;
    exp_overrun = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    tx_done = 1'b1;  // completion during reset must not count
    @(negedge clk);
    tx_done = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_count", crp_count, 16'h0000);

    // Operation resumes normally.
    send_challenge(16'h1234);
    do_eval(5, 1'b0);
    capture_to_wait(1'b0, RESP_A);
    finish_tx(16'h0001);

    repeat (2) @(negedge clk);
    chk("tx_pulse_total", seen_tx_pulses, exp_tx_pulses);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
